// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped cache controller.
package cache_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned DEF_INDEX_BITS = 5;
    localparam int unsigned DEF_WORD_BITS  = 2;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        REFILL,
        RESP,
        WRITE
    } cache_state_e;

    // Tag width left over once index and word-offset fields are removed.
    function automatic int unsigned tag_bits(input int unsigned aw,
                                             input int unsigned ib,
                                             input int unsigned wb);
        return aw - ib - wb;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_line_store.sv
// Valid/tag/data storage for the direct-mapped cache.
// One write port (line tag update and/or word write), combinational read.
module cache_line_store #(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned WORD_BITS  = 2,
    parameter int unsigned TAG_BITS   = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_line_we,
    input  logic                  i_word_we,
    input  logic [INDEX_BITS-1:0] i_idx,
    input  logic [WORD_BITS-1:0]  i_wword,
    input  logic [TAG_BITS-1:0]   i_tag,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [WORD_BITS-1:0]  i_rword,
    output logic                  o_valid,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned WORDS = 1 << WORD_BITS;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES][WORDS];

    // Valid bits: cleared by reset or flush, set when a line finishes refilling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_line_we) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their contents.
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_idx] <= i_tag;
        end
        if (i_word_we) begin
            r_data[i_idx][i_wword] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_rdata = r_data[i_idx][i_rword];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned WORD_BITS  = DEF_WORD_BITS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int unsigned TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS, WORD_BITS);

    cache_state_e          r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [WORD_BITS-1:0]  r_beat;
    logic                  r_flush_pend;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [TAG_BITS-1:0]   w_tag_q;
    logic [INDEX_BITS-1:0] w_idx_q;
    logic [WORD_BITS-1:0]  w_word_q;
    logic                  w_valid;
    logic [TAG_BITS-1:0]   w_tag;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_flush_now;
    logic                  w_line_we;
    logic                  w_word_we;
    logic [WORD_BITS-1:0]  w_wword;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_rd_sel;

    assign w_tag_q  = r_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign w_idx_q  = r_addr[WORD_BITS +: INDEX_BITS];
    assign w_word_q = r_addr[WORD_BITS-1:0];
    assign w_hit    = w_valid && (w_tag == w_tag_q);
    assign w_last   = (r_beat == '1);

    // A flush seen outside IDLE is deferred until the controller is idle again.
    assign w_flush_now = (r_state == IDLE) && (flush || r_flush_pend);
    assign w_line_we   = (r_state == REFILL) && mem_ack && w_last;
    assign w_word_we   = ((r_state == REFILL) && mem_ack) ||
                         ((r_state == WRITE) && mem_ack && w_hit);
    assign w_wword     = (r_state == REFILL) ? r_beat : w_word_q;
    assign w_wdata     = (r_state == REFILL) ? mem_rdata : r_wdata;

    cache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_flush_now),
        .i_line_we (w_line_we),
        .i_word_we (w_word_we),
        .i_idx     (w_idx_q),
        .i_wword   (w_wword),
        .i_tag     (w_tag_q),
        .i_wdata   (w_wdata),
        .i_rword   (w_word_q),
        .o_valid   (w_valid),
        .o_tag     (w_tag),
        .o_rdata   (w_rdata)
    );

    // State register plus request capture, beat counter and pending flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cpu_req) begin
                r_addr  <= cpu_addr;
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end
            if (r_state == COMPARE) begin
                r_beat <= '0;
            end else if (r_state == REFILL && mem_ack) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_state == IDLE) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cpu_req) w_next = COMPARE;
            COMPARE: begin
                if (r_we)       w_next = WRITE;
                else if (w_hit) w_next = IDLE;
                else            w_next = REFILL;
            end
            REFILL:  if (mem_ack && w_last) w_next = RESP;
            RESP:    w_next = IDLE;
            WRITE:   if (mem_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore-style outputs from state; completion pulse is the only ack-dependent term.
    always_comb begin
        cpu_ready = 1'b0;
        w_rd_sel  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            COMPARE: begin
                w_rd_sel  = !r_we && w_hit;
                cpu_ready = !r_we && w_hit;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr[ADDR_WIDTH-1:WORD_BITS], r_beat};
            end
            RESP: begin
                w_rd_sel  = 1'b1;
                cpu_ready = 1'b1;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                cpu_ready = mem_ack;
            end
            default: ;
        endcase
    end

    // Read data holds its last delivered value between completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd_sel) begin
            r_rdata <= w_rdata;
        end
    end

    assign cpu_rdata = w_rd_sel ? w_rdata : r_rdata;

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating hit/miss counters, one event per COMPARE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == COMPARE) begin
            if (w_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: vector table driven through a CPU driver, a memory
// responder with programmable wait states, and an expected-read-data queue.
module tb_dm_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dm_cache_ctrl #(
        .ADDR_WIDTH (16),
        .INDEX_BITS (5),
        .WORD_BITS  (2),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Backing memory: written words are remembered, others follow a fixed pattern.
    logic [31:0] mem_model [logic [15:0]];

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        if (a[15:2] == 14'h28FC) return 32'h100 + {30'd0, a[1:0]};
        return 32'hD000_0000 | {16'd0, a};
    endfunction

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       beat_log [$];
    logic [31:0] sb [$];
    int unsigned mem_wait = 0;
    int unsigned wcnt = 0;

    // Memory responder: acks each beat after mem_wait idle cycles.
    always @(negedge clk) begin
        if (mem_req && !rst) begin
            if (wcnt < mem_wait) begin
                wcnt++;
                mem_ack = 1'b0;
            end else begin
                wcnt = 0;
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                    beat_log.push_back('{1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem_rd(mem_addr);
                    beat_log.push_back('{1'b0, mem_addr, mem_rdata});
                end
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned beats;
        int unsigned lat;
        int unsigned wait_n;
        int unsigned fmode;   // 0 none, 1 flush with request, 2 flush mid-refill
        bit          hit;
    } vec_t;

    task automatic run_vec(input vec_t v, input int unsigned k);
        int unsigned edges;
        bit          got;
        logic [15:0] ea;
        mem_wait = v.wait_n;
        beat_log.delete();
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        if (v.fmode == 1) flush = 1'b1;
        if (!v.we) sb.push_back(v.rdata);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (flush) flush = 1'b0;
            if (v.fmode == 2 && edges == 3) flush = 1'b1;
            #1;
            if (cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        flush   = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL v%0d timeout: no cpu_ready after %0d cycles", k, edges);
            if (!v.we && sb.size() > 0) void'(sb.pop_front());
        end else begin
            chk($sformatf("v%0d latency", k), edges + 1, v.lat);
            if (!v.we && sb.size() > 0) chk($sformatf("v%0d rdata", k), cpu_rdata, sb.pop_front());
        end
        @(negedge clk);
        #1;
        chk($sformatf("v%0d ready_pulse", k), {31'd0, cpu_ready}, 32'd0);
        if (!v.we) chk($sformatf("v%0d rdata_hold", k), cpu_rdata, v.rdata);
        chk($sformatf("v%0d beats", k), beat_log.size(), v.beats);
        for (int i = 0; i < beat_log.size() && i < int'(v.beats); i++) begin
            ea = v.we ? v.addr : {v.addr[15:2], 2'(i)};
            chk($sformatf("v%0d beat%0d addr", k, i), {16'd0, beat_log[i].addr}, {16'd0, ea});
            chk($sformatf("v%0d beat%0d we", k, i), {31'd0, beat_log[i].we}, {31'd0, v.we});
            if (v.we) chk($sformatf("v%0d beat%0d wdata", k, i), beat_log[i].data, v.wdata);
        end
    endtask

    vec_t vecs [22];
    int   exp_hits = 0;
    int   exp_miss = 0;

    initial begin
        vecs[0]  = '{1'b0, 16'hA3F2, 32'h0,        32'h0000_0102, 4, 7,  0, 0, 1'b0};
        vecs[1]  = '{1'b0, 16'hA3F0, 32'h0,        32'h0000_0100, 0, 2,  0, 0, 1'b1};
        vecs[2]  = '{1'b1, 16'hA3F1, 32'hDEADBEEF, 32'h0,         1, 3,  0, 0, 1'b1};
        vecs[3]  = '{1'b0, 16'hA3F1, 32'h0,        32'hDEADBEEF,  0, 2,  0, 0, 1'b1};
        vecs[4]  = '{1'b1, 16'h1234, 32'hCAFEF00D, 32'h0,         1, 3,  0, 0, 1'b0};
        vecs[5]  = '{1'b0, 16'h1234, 32'h0,        32'hCAFEF00D,  4, 7,  0, 0, 1'b0};
        vecs[6]  = '{1'b0, 16'h23F2, 32'h0,        32'hD000_23F2, 4, 7,  0, 0, 1'b0};
        vecs[7]  = '{1'b0, 16'hA3F2, 32'h0,        32'h0000_0102, 4, 7,  0, 0, 1'b0};
        vecs[8]  = '{1'b0, 16'hA3F2, 32'h0,        32'h0000_0102, 0, 2,  0, 0, 1'b1};
        vecs[9]  = '{1'b0, 16'hA3F2, 32'h0,        32'h0000_0102, 4, 7,  0, 1, 1'b0};
        vecs[10] = '{1'b0, 16'h5550, 32'h0,        32'hD000_5550, 4, 7,  0, 2, 1'b0};
        vecs[11] = '{1'b0, 16'h5550, 32'h0,        32'hD000_5550, 4, 7,  0, 0, 1'b0};
        vecs[12] = '{1'b0, 16'hFFFF, 32'h0,        32'hD000_FFFF, 4, 7,  0, 0, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 32'h0,        32'hD000_0000, 4, 7,  0, 0, 1'b0};
        vecs[14] = '{1'b0, 16'hFFFC, 32'h0,        32'hD000_FFFC, 0, 2,  0, 0, 1'b1};
        vecs[15] = '{1'b0, 16'h0001, 32'h0,        32'hD000_0001, 0, 2,  2, 0, 1'b1};
        vecs[16] = '{1'b1, 16'h0002, 32'h11223344, 32'h0,         1, 5,  2, 0, 1'b1};
        vecs[17] = '{1'b0, 16'h0002, 32'h0,        32'h11223344,  0, 2,  2, 0, 1'b1};
        vecs[18] = '{1'b0, 16'h7770, 32'h0,        32'hD000_7770, 4, 11, 1, 0, 1'b0};
        vecs[19] = '{1'b0, 16'hA3F2, 32'h0,        32'h0000_0102, 4, 7,  0, 0, 1'b0};
        vecs[20] = '{1'b0, 16'h4440, 32'h0,        32'hD000_4440, 4, 7,  0, 0, 1'b0};
        vecs[21] = '{1'b0, 16'hA3F2, 32'h0,        32'h0000_0102, 4, 7,  0, 0, 1'b0};

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("rst cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst cpu_rdata", cpu_rdata, 32'd0);
        chk("rst mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst mem_we",    {31'd0, mem_we}, 32'd0);
        chk("rst mem_addr",  {16'd0, mem_addr}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
`ifdef CACHE_STATS_EN
        chk("rst hit_count",  {16'd0, hit_count}, 32'd0);
        chk("rst miss_count", {16'd0, miss_count}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            run_vec(vecs[k], k);
            if (vecs[k].hit) exp_hits++;
            else             exp_miss++;
`ifdef CACHE_STATS_EN
            chk($sformatf("v%0d hit_count", k),  {16'd0, hit_count},  exp_hits);
            chk($sformatf("v%0d miss_count", k), {16'd0, miss_count}, exp_miss);
`endif
        end

        // Reset in the middle of a refill: memory request must drop at once.
        mem_wait = 0;
        beat_log.delete();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h4440;
        for (int i = 0; i < 50 && beat_log.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_mid beats_before", beat_log.size(), 2);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("rst_mid mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_mid cpu_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_mid cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mid mem_addr",  {16'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_miss = 0;

        for (int k = 20; k < 22; k++) begin
            run_vec(vecs[k], k);
            if (vecs[k].hit) exp_hits++;
            else             exp_miss++;
`ifdef CACHE_STATS_EN
            chk($sformatf("v%0d hit_count", k),  {16'd0, hit_count},  exp_hits);
            chk($sformatf("v%0d miss_count", k), {16'd0, miss_count}, exp_miss);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
